// File: rtl/map_arbiter.sv
// Round-robin arbiter that serialises tile reads/writes from NUM_REQ clients
// onto the single-port collision map RAM; one transaction every 3 cycles.
//
// state   | meaning
// IDLE    | pick next eligible client, latch its request, load RAM pins
// ISSUE   | RAM pins asserted for the latched tile (suppressed if off-map)
// CAPTURE | fold RAM read data into o_rdata, pulse o_ack next cycle
module map_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAP_COLS = 50,
  parameter int MAP_ROWS = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_write,
  input  logic [NUM_REQ-1:0]     i_wdata,
  input  logic [6*NUM_REQ-1:0]   i_tile_x,
  input  logic [5*NUM_REQ-1:0]   i_tile_y,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic                   o_rdata,
  output logic                   o_busy,
  output logic                   o_ram_en,
  output logic                   o_ram_write,
  output logic                   o_ram_wdata,
  output logic [5:0]             o_ram_tile_x,
  output logic [4:0]             o_ram_tile_y,
  input  logic                   i_ram_tile_value
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        gnt_q;
  logic                 wr_q;
  logic                 oor_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 rdata_q;
  logic                 ram_en_q;
  logic                 ram_wr_q;
  logic                 ram_wd_q;
  logic [5:0]           ram_x_q;
  logic [4:0]           ram_y_q;

  logic [5:0]           col [NUM_REQ];
  logic [4:0]           row [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        win;
  logic                 found;
  logic [5:0]           win_x;
  logic [4:0]           win_y;
  logic                 win_wr;
  logic                 win_wd;
  logic                 win_oor;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign col[g] = i_tile_x[6*g +: 6];
    assign row[g] = i_tile_y[5*g +: 5];
  end

  // A client whose ack is visible this cycle is masked so it cannot be re-granted early.
  always_comb begin
    eligible = i_req & ~ack_q;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_x   = col[win];
  assign win_y   = row[win];
  assign win_wr  = i_write[win];
  assign win_wd  = i_wdata[win];
  assign win_oor = (32'(win_x) >= MAP_COLS) || (32'(win_y) >= MAP_ROWS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= 1'b0;
      ram_en_q <= 1'b0;
      ram_wr_q <= 1'b0;
      ram_wd_q <= 1'b0;
      ram_x_q  <= '0;
      ram_y_q  <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q    <= win;
            wr_q     <= win_wr;
            oor_q    <= win_oor;
            ram_x_q  <= win_x;
            ram_y_q  <= win_y;
            ram_en_q <= ~win_oor;
            ram_wr_q <= win_wr & ~win_oor;
            ram_wd_q <= win_wd & ~win_oor;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en_q <= 1'b0;
          ram_wr_q <= 1'b0;
          ram_wd_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          // Off-map reads see a wall; writes never return data.
          ack_q   <= NUM_REQ'(1) << gnt_q;
          rdata_q <= wr_q ? 1'b0 : (oor_q ? 1'b1 : i_ram_tile_value);
          ptr_q   <= (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ack        = ack_q;
  assign o_rdata      = rdata_q;
  assign o_busy       = (state_q != IDLE);
  assign o_ram_en     = ram_en_q;
  assign o_ram_write  = ram_wr_q;
  assign o_ram_wdata  = ram_wd_q;
  assign o_ram_tile_x = ram_x_q;
  assign o_ram_tile_y = ram_y_q;

endmodule

// File: tb/tb_map_arbiter.sv
// Bench for map_arbiter: directed and random request batches checked against a
// transaction-level round-robin model with its own copy of the map contents.
module tb_map_arbiter;
  localparam int NR   = 4;
  localparam int COLS = 50;
  localparam int ROWS = 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     wr = '0;
  logic [NR-1:0]     wd = '0;
  logic [6*NR-1:0]   tx = '0;
  logic [5*NR-1:0]   ty = '0;
  logic [NR-1:0]     o_ack;
  logic              o_rdata, o_busy, o_ram_en, o_ram_write, o_ram_wdata;
  logic [5:0]        o_ram_tile_x;
  logic [4:0]        o_ram_tile_y;
  logic              ram_val = 1'b0;

  bit                ram_wr [64][32];
  bit                ram_v  [64][32];
  bit                mdl    [64][32];

  logic [5:0]        cl_x [NR];
  logic [4:0]        cl_y [NR];
  logic [NR-1:0]     cl_wr = '0;
  logic [NR-1:0]     cl_wd = '0;

  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  bit                hold_mode = 1'b0;
  int                model_ptr = 0;
  logic              last_rd = 1'b0;
  logic [31:0]       ack_q[$];
  logic [31:0]       iss_q[$];

  map_arbiter #(.NUM_REQ(NR), .MAP_COLS(COLS), .MAP_ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_write(wr), .i_wdata(wd),
    .i_tile_x(tx), .i_tile_y(ty), .o_ack(o_ack), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_ram_en(o_ram_en), .o_ram_write(o_ram_write), .o_ram_wdata(o_ram_wdata),
    .o_ram_tile_x(o_ram_tile_x), .o_ram_tile_y(o_ram_tile_y), .i_ram_tile_value(ram_val)
  );

  always #5 clk = ~clk;

  function automatic bit pat(logic [5:0] x, logic [4:0] y);
    int h;
    h = int'(x) * 37 + int'(y) * 11 + int'(x) * int'(y);
    return h[2];
  endfunction

  function automatic bit ram_get(logic [5:0] x, logic [4:0] y);
    return ram_wr[x][y] ? ram_v[x][y] : pat(x, y);
  endfunction

  // Registered-read map RAM
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_write) begin
        ram_wr[o_ram_tile_x][o_ram_tile_y] <= 1'b1;
        ram_v[o_ram_tile_x][o_ram_tile_y]  <= o_ram_wdata;
      end else begin
        ram_val <= ram_get(o_ram_tile_x, o_ram_tile_y);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_ram_en === 1'b1)
      iss_q.push_back({16'(cyc), o_ram_tile_x, o_ram_tile_y, o_ram_write, o_ram_wdata, 3'b000});
    if (o_ack !== '0) begin
      ack_q.push_back({16'(cyc), 7'd0, o_rdata, 8'(o_ack)});
      if (!hold_mode) req = req & ~o_ack;
    end
  endtask

  task automatic set_cl(input logic [1:0] k, input logic w, input logic d,
                        input logic [5:0] x, input logic [4:0] y);
    cl_wr[k] = w;
    cl_wd[k] = d;
    cl_x[k]  = x;
    cl_y[k]  = y;
    wr[k] = w;
    wd[k] = d;
    tx[6*k +: 6] = x;
    ty[5*k +: 5] = y;
  endtask

  // Requests from `mask` start this cycle; hold=1 keeps i_req high until n acks.
  task automatic run_batch(input logic [NR-1:0] mask, input bit hold, input int n);
    logic [31:0]   e_ack[$];
    logic [31:0]   e_iss[$];
    logic [NR-1:0] pend;
    logic [1:0]    wi;
    int            t, p, prev, w, idx, b;
    bit            oor, rd;
    e_ack.delete();
    e_iss.delete();
    ack_q.delete();
    iss_q.delete();
    t = cyc + 3;
    p = model_ptr;
    prev = -1;
    pend = mask;
    for (int k = 0; k < n; k++) begin
      w = -1;
      for (int j = 0; j < NR; j++) begin
        idx = (p + j) % NR;
        if (w < 0 && pend[2'(idx)]) w = idx;
      end
      wi = 2'(w);
      if (w == prev) t = t + 1;
      oor = (cl_x[wi] >= 6'(COLS)) || (cl_y[wi] >= 5'(ROWS));
      if (cl_wr[wi]) begin
        rd = 1'b0;
        if (!oor) mdl[cl_x[wi]][cl_y[wi]] = cl_wd[wi];
      end else begin
        rd = oor ? 1'b1 : mdl[cl_x[wi]][cl_y[wi]];
      end
      if (!oor) e_iss.push_back({16'(t - 2), cl_x[wi], cl_y[wi], cl_wr[wi], cl_wd[wi], 3'b000});
      e_ack.push_back({16'(t), 7'd0, rd, 8'(1 << w)});
      last_rd = rd;
      p = (w + 1) % NR;
      if (!hold) pend[wi] = 1'b0;
      prev = w;
      t = t + 3;
    end
    model_ptr = p;

    hold_mode = hold;
    req = mask;
    b = 0;
    while (ack_q.size() < n && b < 4 * n + 12) begin
      tick();
      b++;
    end
    req = '0;
    repeat (4) tick();
    hold_mode = 1'b0;

    chk("ack_count", 32'(ack_q.size()), 32'(n));
    chk("issue_count", 32'(iss_q.size()), 32'(e_iss.size()));
    for (int k = 0; k < n && k < ack_q.size(); k++) chk("ack_cyc_id_rdata", ack_q[k], e_ack[k]);
    for (int k = 0; k < e_iss.size() && k < iss_q.size(); k++) chk("ram_issue", iss_q[k], e_iss[k]);
    chk("rdata_hold", 32'(o_rdata), 32'(last_rd));
    chk("idle_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [NR-1:0] mask;
    int            n;
    bit            hold;
    for (int x = 0; x < 64; x++)
      for (int y = 0; y < 32; y++)
        mdl[x][y] = pat(6'(x), 5'(y));
    for (int k = 0; k < NR; k++) set_cl(2'(k), 1'b0, 1'b0, 6'd0, 5'd0);

    tick();
    tick();
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_ram_en", 32'(o_ram_en), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("reset_ack", 32'(o_ack), 32'd0);
    chk("reset_rdata", 32'(o_rdata), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_ram_pins", {26'd0, o_ram_en, o_ram_write, o_ram_wdata}, 32'd0);
    chk("reset_ram_addr", {21'd0, o_ram_tile_x, o_ram_tile_y}, 32'd0);

    // Single read of a tile that holds 1
    set_cl(2'd1, 1'b1, 1'b1, 6'd3, 5'd4);
    run_batch(4'b0010, 1'b0, 1);
    set_cl(2'd1, 1'b0, 1'b0, 6'd3, 5'd4);
    run_batch(4'b0010, 1'b0, 1);
    chk("single_read_rdata", 32'(last_rd), 32'd1);

    // All four clients hold i_req: strict rotation
    for (int k = 0; k < NR; k++)
      set_cl(2'(k), 1'($urandom % 2), 1'($urandom % 2), 6'($urandom_range(0, COLS - 1)),
             5'($urandom_range(0, ROWS - 1)));
    run_batch(4'b1111, 1'b1, 9);

    // Write then read back
    set_cl(2'd2, 1'b1, 1'b1, 6'd10, 5'd5);
    run_batch(4'b0100, 1'b0, 1);
    set_cl(2'd0, 1'b0, 1'b0, 6'd10, 5'd5);
    run_batch(4'b0001, 1'b0, 1);

    // Leave the pointer at 3, then reset in the middle of ISSUE
    set_cl(2'd2, 1'b0, 1'b0, 6'd7, 5'd7);
    run_batch(4'b0100, 1'b0, 1);
    set_cl(2'd3, 1'b0, 1'b0, 6'd8, 5'd9);
    req = 4'b1000;
    tick();
    chk("pre_rst_ram_en", 32'(o_ram_en), 32'd1);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ram_en", 32'(o_ram_en), 32'd0);
    chk("async_rst_ack", 32'(o_ack), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    ack_q.delete();
    iss_q.delete();
    repeat (6) tick();
    chk("rst_no_stray_ack", 32'(ack_q.size()), 32'd0);
    set_cl(2'd1, 1'b0, 1'b0, 6'd1, 5'd2);
    run_batch(4'b1010, 1'b0, 2);

    // Off-map read and write by client 3
    set_cl(2'd3, 1'b0, 1'b0, 6'd55, 5'd0);
    run_batch(4'b1000, 1'b0, 1);
    chk("oor_read_wall", 32'(last_rd), 32'd1);
    set_cl(2'd3, 1'b1, ~pat(6'd2, 5'd31), 6'd2, 5'd31);
    run_batch(4'b1000, 1'b0, 1);
    chk("oor_write_ram_intact", 32'(ram_get(6'd2, 5'd31)), 32'(pat(6'd2, 5'd31)));

    // Sticky request from client 0 alone
    set_cl(2'd0, 1'b0, 1'b0, 6'd12, 5'd13);
    run_batch(4'b0001, 1'b1, 3);

    for (int r = 0; r < 40; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < NR; k++)
        set_cl(2'(k), 1'($urandom % 2), 1'($urandom % 2),
               ($urandom_range(0, 3) == 0) ? 6'($urandom_range(COLS, 63)) : 6'($urandom_range(0, COLS - 1)),
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(ROWS, 31)) : 5'($urandom_range(0, ROWS - 1)));
      hold = ($urandom_range(0, 3) == 0);
      n = hold ? int'($urandom_range(2, 7)) : $countones(mask);
      run_batch(mask, hold, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
